// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, the 320x240 RGB444 frame
// buffer geometry and the pixel type. The buffer RAM and its writers use
// the same package.
package vga_pkg;

    // Horizontal timing in pixels
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Frame buffer geometry, upscaled 2x on the screen
    localparam int IMG_W    = 320;
    localparam int IMG_H    = 240;
    localparam int PIX_W    = 12;
    localparam int ROW_W    = 8;
    localparam int COL_W    = 9;

    // Width of the beam position counters (800 pixels / 525 lines fit in 10 bits)
    localparam int CNT_W    = 10;

    typedef logic [PIX_W-1:0] pixel_t;

    // RGB444 word as stored in the frame buffer, red in the top nibble
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t RGB_BLACK = '0;

    // True when a counter value lies in [first, first+len)
    function automatic logic inSpan(input logic [CNT_W-1:0] cnt, input int first, input int len);
        return (int'(cnt) >= first) && (int'(cnt) < first + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA beam timing: pixel-clock divider, horizontal/vertical position
// counters, raw active-low syncs, the active-video flag and the
// start-of-frame tick. Everything advances only while enabled.
module vga_timing_gen #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    output logic                      o_pixTick,
    output logic                      o_frameTick,
    output logic [vga_pkg::CNT_W-1:0] o_hCnt,
    output logic [vga_pkg::CNT_W-1:0] o_vCnt,
    output logic                      o_hsyncRaw,
    output logic                      o_vsyncRaw,
    output logic                      o_active
);
    import vga_pkg::*;

    localparam int H_PERIOD = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_PERIOD = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A one-clock-per-pixel build still needs a one-bit divider register
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_PERIOD - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_PERIOD - 1);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_hCnt;
    logic [CNT_W-1:0] r_vCnt;
    logic             r_firstPending;

    logic w_pixTick;
    logic w_hWrap;
    logic w_vWrap;

    // Reset is folded in so no tick (and so no frame pulse) can appear
    // while reset is held, whatever the divider held before it.
    assign w_pixTick = i_enable && !i_rst && (r_div == DIV_LAST);
    assign w_hWrap   = (r_hCnt == H_LAST);
    assign w_vWrap   = (r_vCnt == V_LAST);

    // Pixel divider: free-runs 0..PIX_DIV-1 while enabled, freezes otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (i_enable) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    // Horizontal position: one step per pixel, wrapping at the end of the line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hCnt <= '0;
        end else if (w_pixTick) begin
            r_hCnt <= w_hWrap ? '0 : r_hCnt + 1'b1;
        end
    end

    // Vertical position: one step per completed line, wrapping at frame end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vCnt <= '0;
        end else if (w_pixTick && w_hWrap) begin
            r_vCnt <= w_vWrap ? '0 : r_vCnt + 1'b1;
        end
    end

    // Remembers that the first pixel after reset has not been ticked yet
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_firstPending <= 1'b1;
        end else if (w_pixTick) begin
            r_firstPending <= 1'b0;
        end
    end

    // Frame boundary: the tick that wraps both counters, or the very first
    // tick after reset so a consumer can lock on without waiting a frame.
    assign o_frameTick = w_pixTick && (r_firstPending || (w_hWrap && w_vWrap));

    assign o_pixTick  = w_pixTick;
    assign o_hCnt     = r_hCnt;
    assign o_vCnt     = r_vCnt;
    assign o_hsyncRaw = !inSpan(r_hCnt, H_ACTIVE + H_FP, H_SYNC);
    assign o_vsyncRaw = !inSpan(r_vCnt, V_ACTIVE + V_FP, V_SYNC);
    assign o_active   = (int'(r_hCnt) < H_ACTIVE) && (int'(r_vCnt) < V_ACTIVE);

endmodule

// File: rtl/vga_scan_reader.sv
// Scans a 320x240 RGB444 frame buffer onto a 640x480 VGA raster. Each
// buffer pixel covers a 2x2 block of screen pixels. The buffer is read
// combinationally; colour and syncs are registered together on the pixel
// tick so they leave the block aligned, one pixel behind the counters.
module vga_scan_reader #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      enable,
    output logic [vga_pkg::ROW_W-1:0] row_read,
    output logic [vga_pkg::COL_W-1:0] col_read,
    input  logic [vga_pkg::PIX_W-1:0] ram_pixel_in,
    output logic [3:0]                vga_r,
    output logic [3:0]                vga_g,
    output logic [3:0]                vga_b,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic                      frame_start
);
    import vga_pkg::*;

    logic             w_pixTick;
    logic             w_frameTick;
    logic [CNT_W-1:0] w_hCnt;
    logic [CNT_W-1:0] w_vCnt;
    logic             w_hsyncRaw;
    logic             w_vsyncRaw;
    logic             w_active;
    logic [2:0]       w_unusedCntBits;

    rgb444_t r_rgb;
    logic    r_hsync;
    logic    r_vsync;

    vga_timing_gen #(
        .PIX_DIV  (PIX_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk       (Clock),
        .i_rst       (Reset),
        .i_enable    (enable),
        .o_pixTick   (w_pixTick),
        .o_frameTick (w_frameTick),
        .o_hCnt      (w_hCnt),
        .o_vCnt      (w_vCnt),
        .o_hsyncRaw  (w_hsyncRaw),
        .o_vsyncRaw  (w_vsyncRaw),
        .o_active    (w_active)
    );

    // Dropping the counter LSBs gives the 2x upscale. Addresses are parked
    // at 0 in blanking so the RAM sees a stable address there.
    assign row_read = w_active ? w_vCnt[8:1] : '0;
    assign col_read = w_active ? w_hCnt[9:1] : '0;

    // The scaled-away LSBs and the spare top bit of the line counter
    assign w_unusedCntBits = {w_vCnt[9], w_vCnt[0], w_hCnt[0]};

    // Output stage: reset wins over enable; disabling blanks at once; otherwise
    // colour and syncs are captured together once per pixel.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rgb   <= RGB_BLACK;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (!enable) begin
            r_rgb   <= RGB_BLACK;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_pixTick) begin
            r_rgb   <= w_active ? rgb444_t'(ram_pixel_in) : RGB_BLACK;
            r_hsync <= w_hsyncRaw;
            r_vsync <= w_vsyncRaw;
        end
    end

    assign vga_r       = r_rgb.r;
    assign vga_g       = r_rgb.g;
    assign vga_b       = r_rgb.b;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign frame_start = w_frameTick;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Bench for vga_scan_reader. Horizontal timing is the standard 640-pixel
// line; the frame is shortened to 12 lines so several frames fit in a short
// run. A behavioural beam model pushes expected output words into a
// scoreboard on the clock edge, and they are popped and compared on the
// following falling edge. Sync and frame edge timings are logged and
// compared against numbers derived from the timing parameters.
module tb_vga_scan_reader;

    localparam int PD = 2;
    localparam int HA = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = VA + VF + VS + VB;
    localparam int LINE_CLK  = HT * PD;
    localparam int FRAME_CLK = LINE_CLK * VT;

    logic       Clock;
    logic       Reset;
    logic       enable;
    logic [7:0] row_read;
    logic [8:0] col_read;
    logic [11:0] ram_pixel_in;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       frame_start;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } expT;

    expT   expQ[$];
    string tagQ[$];

    int hsFalls[$];
    int hsRises[$];
    int vsFalls[$];
    int vsRises[$];
    int fsList[$];

    int   cyc  = 0;
    int   mDiv = 0;
    int   mH   = 0;
    int   mV   = 0;
    logic mFirst = 1'b1;
    logic prevHs = 1'b1;
    logic prevVs = 1'b1;

    // Frame buffer contents: two fixed probe pixels, a hash elsewhere
    function automatic logic [11:0] ramData(input logic [7:0] r, input logic [8:0] c);
        int t;
        if (r == 8'd0 && c == 9'd0) return 12'hFFF;
        if (r == 8'd3 && c == 9'd2) return 12'hABC;
        t = (int'(r) * 29) ^ (int'(c) * 7) ^ 32'h5A3;
        return t[11:0];
    endfunction

    // Expected {row, col} for a beam position
    function automatic logic [16:0] addrOf(input int h, input int v);
        logic [9:0] hh;
        logic [9:0] vv;
        hh = h[9:0];
        vv = v[9:0];
        if (h < HA && v < VA) return {vv[8:1], hh[9:1]};
        return 17'd0;
    endfunction

    function automatic logic isCheckCol(input int h);
        return h inside {0, 1, 4, 5, 6, HA-1, HA, HA+1, HA+HF-1, HA+HF,
                         HA+HF+HS-1, HA+HF+HS, HT-1};
    endfunction

    assign ram_pixel_in = ramData(row_read, col_read);

    vga_scan_reader #(
        .PIX_DIV  (PD),
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HS),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .enable       (enable),
        .row_read     (row_read),
        .col_read     (col_read),
        .ram_pixel_in (ram_pixel_in),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hsync    (vga_hsync),
        .vga_vsync    (vga_vsync),
        .frame_start  (frame_start)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, well clear of it
    task automatic applyStimulus(input logic rst, input logic en, input int n);
        Reset  = rst;
        enable = en;
        repeat (n) begin
            @(posedge Clock);
            #2;
        end
    endtask

    // Beam model: advances like the spec describes and queues expectations
    always @(posedge Clock) begin : model
        expT  e;
        logic act;
        logic [16:0] a;
        if (Reset) begin
            cyc    <= 0;
            mDiv   <= 0;
            mH     <= 0;
            mV     <= 0;
            mFirst <= 1'b1;
            e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
            expQ.push_back(e);
            tagQ.push_back("reset");
        end else begin
            cyc <= cyc + 1;
            if (!enable) begin
                e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
                expQ.push_back(e);
                tagQ.push_back("disabled");
            end else if (mDiv == PD - 1) begin
                act   = (mH < HA) && (mV < VA);
                a     = addrOf(mH, mV);
                e.rgb = act ? ramData(a[16:9], a[8:0]) : 12'h000;
                e.hs  = !(mH >= HA + HF && mH < HA + HF + HS);
                e.vs  = !(mV >= VA + VF && mV < VA + VF + VS);
                if (isCheckCol(mH) || $urandom_range(0, 31) == 0) begin
                    expQ.push_back(e);
                    tagQ.push_back($sformatf("pix_h%0d_v%0d", mH, mV));
                end
                mDiv   <= 0;
                mFirst <= 1'b0;
                if (mH == HT - 1) begin
                    mH <= 0;
                    mV <= (mV == VT - 1) ? 0 : mV + 1;
                end else begin
                    mH <= mH + 1;
                end
            end else begin
                mDiv <= mDiv + 1;
            end
        end
    end

    // Falling-edge monitor: scoreboard pops, frame pulse and edge logging
    always @(negedge Clock) begin : monitor
        expT   e;
        string t;
        logic  expFs;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput({t, "_rgb"},  32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
            checkOutput({t, "_sync"}, 32'({vga_hsync, vga_vsync}), 32'({e.hs, e.vs}));
            checkOutput({t, "_addr"}, 32'({row_read, col_read}), 32'(addrOf(mH, mV)));
        end
        expFs = enable && !Reset && (mDiv == PD - 1) && (mFirst || (mH == HT - 1 && mV == VT - 1));
        if (expFs || frame_start) checkOutput("frame_start", 32'(frame_start), 32'(expFs));
        if (frame_start === 1'b1) fsList.push_back(cyc);
        if (prevHs === 1'b1 && vga_hsync === 1'b0) hsFalls.push_back(cyc);
        if (prevHs === 1'b0 && vga_hsync === 1'b1) hsRises.push_back(cyc);
        if (prevVs === 1'b1 && vga_vsync === 1'b0) vsFalls.push_back(cyc);
        if (prevVs === 1'b0 && vga_vsync === 1'b1) vsRises.push_back(cyc);
        prevHs = vga_hsync;
        prevVs = vga_vsync;
    end

    initial begin : stim
        int n;
        int nf;
        int nh;

        Reset  = 1'b1;
        enable = 1'b1;
        applyStimulus(1'b1, 1'b1, 4);
        checkOutput("rst_rgb",   32'({vga_r, vga_g, vga_b}), 32'h0);
        checkOutput("rst_hsync", 32'(vga_hsync), 32'h1);
        checkOutput("rst_vsync", 32'(vga_vsync), 32'h1);
        checkOutput("rst_fs",    32'(frame_start), 32'h0);
        checkOutput("rst_row",   32'(row_read), 32'h0);
        checkOutput("rst_col",   32'(col_read), 32'h0);

        // Free run through two full frames
        n = 0;
        while (fsList.size() < 3 && n < 2 * FRAME_CLK + 1000) begin
            applyStimulus(1'b0, 1'b1, 1);
            n++;
        end
        checkOutput("fs_count", 32'(fsList.size()), 32'd3);
        if (fsList.size() >= 3) begin
            checkOutput("fs_first_cycle",  32'(fsList[0]), 32'd1);
            checkOutput("fs_second_cycle", 32'(fsList[1]), 32'(FRAME_CLK - 1));
            checkOutput("fs_period",       32'(fsList[2] - fsList[1]), 32'(FRAME_CLK));
        end
        checkOutput("hs_edges_seen", 32'(hsFalls.size() >= 2 && hsRises.size() >= 1), 32'd1);
        if (hsFalls.size() >= 2 && hsRises.size() >= 1) begin
            checkOutput("hs_first_fall", 32'(hsFalls[0]), 32'(PD * (HA + HF + 1)));
            checkOutput("hs_low_width",  32'(hsRises[0] - hsFalls[0]), 32'(PD * HS));
            checkOutput("hs_period",     32'(hsFalls[1] - hsFalls[0]), 32'(LINE_CLK));
        end
        checkOutput("vs_edges_seen", 32'(vsFalls.size() >= 1 && vsRises.size() >= 1), 32'd1);
        if (vsFalls.size() >= 1 && vsRises.size() >= 1) begin
            checkOutput("vs_first_fall", 32'(vsFalls[0]), 32'(PD * ((VA + VF) * HT + 1)));
            checkOutput("vs_low_width",  32'(vsRises[0] - vsFalls[0]), 32'(VS * LINE_CLK));
        end

        // Pause for 100 clocks in the middle of an active line
        n = 0;
        while (mH != 300 && n < 2 * LINE_CLK) begin
            applyStimulus(1'b0, 1'b1, 1);
            n++;
        end
        checkOutput("reach_h300", 32'(mH), 32'd300);
        nf = hsFalls.size();
        applyStimulus(1'b0, 1'b0, 100);
        n = 0;
        while (hsFalls.size() <= nf && n < 2 * LINE_CLK) begin
            applyStimulus(1'b0, 1'b1, 1);
            n++;
        end
        checkOutput("hs_fall_after_pause", 32'(hsFalls.size() > nf), 32'd1);
        if (hsFalls.size() > nf && nf >= 1)
            checkOutput("hs_period_paused", 32'(hsFalls[nf] - hsFalls[nf - 1]), 32'(LINE_CLK + 100));

        // Reset in the middle of a line, in the middle of the frame
        n = 0;
        while (!(mV == 5 && mH == 200) && n < FRAME_CLK + LINE_CLK) begin
            applyStimulus(1'b0, 1'b1, 1);
            n++;
        end
        checkOutput("reach_v5", 32'(mV), 32'd5);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("midrst_rgb",   32'({vga_r, vga_g, vga_b}), 32'h0);
        checkOutput("midrst_hsync", 32'(vga_hsync), 32'h1);
        checkOutput("midrst_vsync", 32'(vga_vsync), 32'h1);
        checkOutput("midrst_fs",    32'(frame_start), 32'h0);
        checkOutput("midrst_row",   32'(row_read), 32'h0);
        checkOutput("midrst_col",   32'(col_read), 32'h0);
        applyStimulus(1'b1, 1'b1, 2);
        nf = fsList.size();
        nh = hsFalls.size();
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("fs_after_rst_count", 32'(fsList.size()), 32'(nf + 1));
        if (fsList.size() > nf)
            checkOutput("fs_after_rst_cycle", 32'(fsList[nf]), 32'd1);
        applyStimulus(1'b0, 1'b1, 2000);
        checkOutput("hs_fall_after_rst_seen", 32'(hsFalls.size() > nh), 32'd1);
        if (hsFalls.size() > nh)
            checkOutput("hs_fall_after_rst", 32'(hsFalls[nh]), 32'(PD * (HA + HF + 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scan_reader.md
VGA_SCAN_READER -- requirements
Module: vga_scan_reader

Interface
REQ-001 Parameter PIX_DIV, default 2, meaning system clocks per VGA pixel (50 MHz Clock gives 25 MHz pixel).
REQ-002 Parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48; V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33; meaning standard 640x480@60 timing in pixels/lines.
REQ-003 Clock  in  1  system clock; single clock domain, all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  when low, counters hold and outputs are blanked.
REQ-006 row_read  out  8  frame-buffer row address (0..239).
REQ-007 col_read  out  9  frame-buffer column address (0..319).
REQ-008 ram_pixel_in  in  12  RGB444 read data from the frame buffer, combinational from row_read/col_read.
REQ-009 vga_r, vga_g, vga_b  out  4 each  pixel colour to DAC.
REQ-010 vga_hsync, vga_vsync  out  1 each  active-low sync.
REQ-011 frame_start  out  1  one-Clock pulse at start of each frame.

Function
REQ-012 Divider counts 0..PIX_DIV-1 while enable=1; pix_tick asserted for one Clock when divider equals PIX_DIV-1.
REQ-013 h_cnt counts 0..799 on pix_tick, wraps to 0; v_cnt increments when h_cnt wraps, counts 0..524, wraps to 0.
REQ-014 Active region: h_cnt<640 and v_cnt<480.
REQ-015 row_read = v_cnt[8:1], col_read = h_cnt[9:1] in active region (2x upscale of 320x240 buffer); both 0 outside it.
REQ-016 Raw hsync low for h_cnt in 656..751; raw vsync low for v_cnt in 490..491.
REQ-017 On pix_tick, outputs register: colour = ram_pixel_in if active else 0; sync = raw sync; latency exactly one pixel from counter to output, colour and sync aligned.
REQ-018 vga_r = ram_pixel_in[11:8], vga_g = [7:4], vga_b = [3:0].
REQ-019 frame_start pulses for the Clock in which pix_tick occurs with h_cnt=799 and v_cnt=524 (or first tick after reset).
REQ-020 enable low: divider, h_cnt, v_cnt hold; colour forced 0 and syncs driven high on next Clock; resume continues from held counts.
REQ-021 Outputs change only on pix_tick Clocks except REQ-020 blanking and reset.

Reset
REQ-022 Reset clears divider, h_cnt, v_cnt to 0.
REQ-023 Reset values: colour 0, vga_hsync 1, vga_vsync 1, frame_start 0, row_read 0, col_read 0.
REQ-024 Reset asserted mid-line or mid-frame restarts timing at h_cnt=0, v_cnt=0 on the Clock after release; Reset has priority over enable.

Structure
REQ-025 Timing constants (REQ-002), image size 320x240, and pixel width 12 belong in shared package vga_pkg for reuse by the buffer RAM and writers.
REQ-026 One sub-module vga_timing_gen (divider, h/v counters, raw syncs, active flag); vga_scan_reader adds address map and output register.

Verification
REQ-027 After reset, enable=1, PIX_DIV=2: vga_hsync first falls 2*657 Clocks after release, low for 192 Clocks; period 1600 Clocks.
REQ-028 Full frame: vga_vsync low exactly 2 lines (3200 Clocks); frame_start pulses every 840000 Clocks.
REQ-029 h_cnt=5,v_cnt=7 -> row_read=3, col_read=2; ram_pixel_in=0xABC -> vga_r=A,g=B,b=C next pix_tick.
REQ-030 h_cnt=640 with ram_pixel_in=0xFFF -> colour 0, addresses 0.
REQ-031 enable low for 100 Clocks mid-line -> counts hold, outputs blank; after re-enable, hsync timing shifted by exactly 100 Clocks.
REQ-032 Reset at v_cnt=300 -> outputs at reset values next Clock; frame_start first pixel after release.
